// File: rtl/bram_stream_reader.sv
// Burst reader for the shared single-port block RAM: issues `length` sequential reads,
// absorbs the fixed read latency, and streams the words out through a 4-entry credit FIFO.
module bram_stream_reader #(
  parameter int    DATA_WIDTH      = 32,
  parameter int    DEPTH           = 65536,
  parameter string OUTPUT_REGISTER = "false",
  localparam int   AW              = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW:0]           length,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         bram_rd_addr,
  output logic                  bram_rd_en,
  input  logic [DATA_WIDTH-1:0] bram_rd_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic                  o_last
);

  localparam int          LAT   = (OUTPUT_REGISTER == "true") ? 2 : 1;
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [AW-1:0]         r_addr;
  logic [AW:0]           r_rd_rem;
  logic [AW:0]           r_out_rem;
  logic [LAT-1:0]        r_vld_pipe;
  logic [DATA_WIDTH-1:0] r_fifo [4];
  logic [1:0]            r_wptr, r_rptr;
  logic [2:0]            r_count;

  logic       w_accept, w_rd_en, w_push, w_pop;
  logic [2:0] w_inflight;
  logic [3:0] w_used;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LAT; i++) w_inflight = w_inflight + 3'(r_vld_pipe[i]);
  end

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_push   = r_vld_pipe[LAT-1];
  assign w_pop    = o_valid && o_ready;
  assign w_used   = {1'b0, r_count} + {1'b0, w_inflight};
  // The slot being popped this cycle can be handed to a new read right away.
  assign w_rd_en  = (r_state == S_READ) && (r_rd_rem != '0) &&
                    (w_used < (4'd4 + {3'b000, w_pop}));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (length == '0) ? S_DONE : S_READ;
      S_READ:  if (w_rd_en && (r_rd_rem == ONE)) w_state_nxt = S_DRAIN;
      // Popping the final word implies nothing in flight and the FIFO emptying.
      S_DRAIN: if (w_pop && o_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_rd_rem   <= '0;
      r_out_rem  <= '0;
      r_vld_pipe <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      for (int i = 0; i < 4; i++) r_fifo[i] <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_addr    <= base_addr;
        r_rd_rem  <= length;
        r_out_rem <= length;
      end else begin
        if (w_rd_en) begin
          r_addr   <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
          r_rd_rem <= r_rd_rem - ONE;
        end
        if (w_pop) r_out_rem <= r_out_rem - ONE;
      end

      r_vld_pipe[0] <= w_rd_en;
      for (int i = 1; i < LAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];

      if (w_push) begin
        r_fifo[r_wptr] <= bram_rd_data;
        r_wptr         <= r_wptr + 2'd1;
      end
      if (w_pop) r_rptr <= r_rptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign busy         = (r_state == S_READ) || (r_state == S_DRAIN);
  assign done         = (r_state == S_DONE);
  assign bram_rd_addr = r_addr;
  assign bram_rd_en   = w_rd_en;
  assign o_data       = r_fifo[r_rptr];
  assign o_valid      = (r_count != '0);
  assign o_last       = o_valid && (r_out_rem == ONE);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(w_push && !w_pop && (r_count == 3'd4)));

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench: two readers (read latency 1 and 2) on a 16-word RAM model;
// stimulus queues expected addresses/words, a negedge monitor pops and compares.
module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        st   [2];
  logic [3:0]  ba   [2];
  logic [4:0]  ln   [2];
  logic        rdy  [2];
  logic        busy [2];
  logic        done [2];
  logic [3:0]  radr [2];
  logic        ren  [2];
  logic [31:0] rdat [2];
  logic [31:0] od   [2];
  logic        vld  [2];
  logic        last [2];
  logic [31:0] ram_d1 [2];
  logic [31:0] ram_d2 [2];

  int n_pass = 0;
  int n_tot  = 0;
  int xfer [2];

  logic [3:0]  qa0 [$];
  logic [3:0]  qa1 [$];
  logic [32:0] qd0 [$];
  logic [32:0] qd1 [$];

  always #5 clk = ~clk;

  bram_stream_reader #(.DATA_WIDTH(32), .DEPTH(16), .OUTPUT_REGISTER("false")) u_lat1 (
    .clk(clk), .rstn(rstn), .start(st[0]), .base_addr(ba[0]), .length(ln[0]),
    .busy(busy[0]), .done(done[0]), .bram_rd_addr(radr[0]), .bram_rd_en(ren[0]),
    .bram_rd_data(rdat[0]), .o_data(od[0]), .o_valid(vld[0]), .o_ready(rdy[0]),
    .o_last(last[0]));

  bram_stream_reader #(.DATA_WIDTH(32), .DEPTH(16), .OUTPUT_REGISTER("true")) u_lat2 (
    .clk(clk), .rstn(rstn), .start(st[1]), .base_addr(ba[1]), .length(ln[1]),
    .busy(busy[1]), .done(done[1]), .bram_rd_addr(radr[1]), .bram_rd_en(ren[1]),
    .bram_rd_data(rdat[1]), .o_data(od[1]), .o_valid(vld[1]), .o_ready(rdy[1]),
    .o_last(last[1]));

  function automatic logic [31:0] ramw(input logic [3:0] a);
    return 32'hC0DE_0000 | {28'h0, a};
  endfunction

  // RAM model: registered read, plus an output register stage for the second reader
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ren[k]) ram_d1[k] <= ramw(radr[k]);
      ram_d2[k] <= ram_d1[k];
    end
  end
  assign rdat[0] = ram_d1[0];
  assign rdat[1] = ram_d2[1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic unexpected(input string nm);
    n_tot++;
    $display("FAIL %s: got an unexpected event, expected none", nm);
  endtask

  task automatic pop_a(input int k, output bit ok, output logic [3:0] v);
    ok = 1'b0; v = '0;
    if (k == 0) begin
      if (qa0.size() != 0) begin v = qa0.pop_front(); ok = 1'b1; end
    end else if (qa1.size() != 0) begin
      v = qa1.pop_front(); ok = 1'b1;
    end
  endtask

  task automatic pop_d(input int k, output bit ok, output logic [32:0] v);
    ok = 1'b0; v = '0;
    if (k == 0) begin
      if (qd0.size() != 0) begin v = qd0.pop_front(); ok = 1'b1; end
    end else if (qd1.size() != 0) begin
      v = qd1.pop_front(); ok = 1'b1;
    end
  endtask

  function automatic int pending(input int k);
    return (k == 0) ? (qa0.size() + qd0.size()) : (qa1.size() + qd1.size());
  endfunction

  bit          m_ok;
  logic [3:0]  m_a;
  logic [32:0] m_d;

  always @(negedge clk) begin
    if (rstn) begin
      for (int k = 0; k < 2; k++) begin
        if (ren[k]) begin
          pop_a(k, m_ok, m_a);
          if (!m_ok) unexpected($sformatf("rd_en%0d", k));
          else chk($sformatf("rd_addr%0d", k), 64'(radr[k]), 64'(m_a));
        end
        if (vld[k] && rdy[k]) begin
          pop_d(k, m_ok, m_d);
          if (!m_ok) unexpected($sformatf("o_valid%0d", k));
          else chk($sformatf("last_data%0d", k), 64'({last[k], od[k]}), 64'(m_d));
          xfer[k] <= xfer[k] + 1;
        end
      end
    end
  end

  // Called one step after a rising edge; the next rising edge is E0.
  task automatic go(input int k, input logic [3:0] b, input logic [4:0] l);
    logic [3:0] a;
    st[k] = 1'b1; ba[k] = b; ln[k] = l;
    for (int i = 0; i < int'(l); i++) begin
      a = b + 4'(i);
      if (k == 0) begin qa0.push_back(a); qd0.push_back({i == int'(l) - 1, ramw(a)}); end
      else begin qa1.push_back(a); qd1.push_back({i == int'(l) - 1, ramw(a)}); end
    end
    @(posedge clk); #1;
    st[k] = 1'b0;
  endtask

  // Starts in the cycle after E0 with o_ready high throughout.
  task automatic burst_check(input int k, input int len, input int lat, input string nm);
    int n, fv;
    chk({nm, " busy_after_start"}, 64'(busy[k]), 64'd1);
    chk({nm, " rd_en_after_start"}, 64'(ren[k]), 64'd1);
    n = 1;
    while (!vld[k] && n < 40) begin @(posedge clk); #1; n++; end
    chk({nm, " first_valid_cycle"}, 64'(n), 64'(lat + 2));
    fv = n;
    while (!done[k] && n < 200) begin @(posedge clk); #1; n++; end
    chk({nm, " done_after_first_valid"}, 64'(n - fv), 64'(len));
    chk({nm, " busy_in_done"}, 64'(busy[k]), 64'd0);
    @(posedge clk); #1;
    chk({nm, " done_pulse_width"}, 64'(done[k]), 64'd0);
    chk({nm, " scoreboard_drained"}, 64'(pending(k)), 64'd0);
  endtask

  initial begin
    int n, cnt, x0;
    for (int k = 0; k < 2; k++) begin
      st[k] = 1'b0; ba[k] = '0; ln[k] = '0; rdy[k] = 1'b1; xfer[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_outputs%0d", k),
          64'({busy[k], done[k], ren[k], vld[k], last[k], radr[k], od[k]}), 64'd0);
    end
    #2 rstn = 1'b1;
    @(posedge clk); #1;

    go(0, 4'd10, 5'd5); burst_check(0, 5, 1, "basic_lat1");
    go(1, 4'd10, 5'd5); burst_check(1, 5, 2, "basic_lat2");
    go(0, 4'd14, 5'd4); burst_check(0, 4, 1, "wrap");

    go(0, 4'd5, 5'd0);
    chk("zero_len done", 64'(done[0]), 64'd1);
    chk("zero_len busy/rd_en/valid", 64'({busy[0], ren[0], vld[0]}), 64'd0);
    @(posedge clk); #1;
    chk("zero_len done_pulse", 64'(done[0]), 64'd0);

    // mid-burst start and start-on-done must both be ignored
    go(0, 4'd0, 5'd8);
    @(posedge clk); #1;
    st[0] = 1'b1; ba[0] = 4'd9; ln[0] = 5'd8;
    @(posedge clk); #1;
    st[0] = 1'b0;
    n = 0;
    while (!done[0] && n < 100) begin @(posedge clk); #1; n++; end
    chk("ignored_start done_seen", 64'(done[0]), 64'd1);
    st[0] = 1'b1; ba[0] = 4'd0; ln[0] = 5'd3;
    @(posedge clk); #1;
    st[0] = 1'b0;
    chk("start_on_done ignored", 64'({busy[0], ren[0]}), 64'd0);
    chk("ignored_start scoreboard", 64'(pending(0)), 64'd0);

    rdy[0] = 1'b0;
    go(0, 4'd3, 5'd16);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cnt += int'(ren[0]);
      @(posedge clk); #1;
    end
    chk("stall rd_en_count", 64'(cnt), 64'd4);
    chk("stall valid_held", 64'(vld[0]), 64'd1);
    chk("stall head_data", 64'(od[0]), 64'(ramw(4'd3)));
    rdy[0] = 1'b1;
    n = 0;
    while (!done[0] && n < 100) begin @(posedge clk); #1; n++; end
    chk("stall done_seen", 64'(done[0]), 64'd1);
    @(posedge clk); #1;
    chk("stall scoreboard", 64'(pending(0)), 64'd0);

    x0 = xfer[0];
    go(0, 4'd4, 5'd8);
    n = 0;
    while ((xfer[0] - x0) < 3 && n < 50) begin @(negedge clk); #1; n++; end
    chk("reset_mid transfers_before", 64'(xfer[0] - x0), 64'd3);
    @(posedge clk); #1;
    rstn = 1'b0;
    qa0.delete(); qd0.delete();
    #1;
    chk("reset_mid outputs",
        64'({busy[0], done[0], ren[0], vld[0], last[0], radr[0], od[0]}), 64'd0);
    @(posedge clk); #2;
    rstn = 1'b1;
    @(posedge clk); #1;
    go(0, 4'd0, 5'd2); burst_check(0, 2, 1, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
